// File: rtl/sprite_pixel_pipe.sv
// Sprite pixel pipe: maps the beam position to a sprite ROM address and a palette colour.
// Latency: 3 clk (ADDR register, ROM read, output register).
// Backpressure: none; one pixel accepted every cycle, bubbles flow through as pix_valid=0.
module sprite_pixel_pipe #(
  parameter int SPR_W = 26,
  parameter int SPR_H = 32
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        flip,
  output logic [9:0]  ADDR,
  input  logic [2:0]  q,
  output logic        valid_out,
  output logic        sprite_on,
  output logic [23:0] rgb
);

  localparam logic [10:0] SPR_W11 = 11'(SPR_W);
  localparam logic [10:0] SPR_H11 = 11'(SPR_H);
  localparam logic [9:0]  SPR_W10 = 10'(SPR_W);

  // Shadow position/orientation, only updated during vertical blank
  logic [9:0] sx_q, sx_d;
  logic [9:0] sy_q, sy_d;
  logic       sflip_q, sflip_d;

  // Stage 1: ROM address plus valid/hit
  logic [9:0] addr_q, addr_d;
  logic       v1_q, v1_d;
  logic       h1_q, h1_d;

  // Stage 2: aligned with the ROM data q
  logic       v2_q, v2_d;
  logic       h2_q, h2_d;

  // Stage 3: output registers
  logic        valid_out_q, valid_out_d;
  logic        sprite_on_q, sprite_on_d;
  logic [23:0] rgb_q, rgb_d;

  // Stage 0 intermediates
  logic [10:0] dx, dy;
  logic        in_box;
  logic [9:0]  col;
  logic [9:0]  addr_calc;
  logic [23:0] pal;

  // Shadow registers latch the requested position only on frame_start; the
  // pixel sampled in that same cycle still sees the old values.
  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    sflip_d = sflip_q;
    if (frame_start) begin
      sx_d    = pos_x;
      sy_d    = pos_y;
      sflip_d = flip;
    end
  end

  // Stage 0: box test and address; 11-bit differences keep the sign so a
  // sprite near column/row 1023 never wraps onto low coordinates.
  always_comb begin
    dx        = {1'b0, DrawX} - {1'b0, sx_q};
    dy        = {1'b0, DrawY} - {1'b0, sy_q};
    in_box    = pix_valid && !dx[10] && !dy[10] && (dx < SPR_W11) && (dy < SPR_H11);
    col       = sflip_q ? (SPR_W10 - 10'd1 - dx[9:0]) : dx[9:0];
    addr_calc = dy[9:0] * SPR_W10 + col;
    addr_d    = in_box ? addr_calc : 10'd0;
    v1_d      = pix_valid;
    h1_d      = in_box;
    v2_d      = v1_q;
    h2_d      = h1_q;
  end

  // Output stage: palette lookup, index 0 is transparent and forces black.
  always_comb begin
    pal = 24'h000000;
    case (q)
      3'd1:    pal = 24'hFF0000;
      3'd2:    pal = 24'h8B4513;
      3'd3:    pal = 24'hFFCC99;
      3'd4:    pal = 24'h0000FF;
      3'd5:    pal = 24'hFFFF00;
      3'd6:    pal = 24'h000000;
      3'd7:    pal = 24'hFFFFFF;
      default: pal = 24'h000000;
    endcase
    valid_out_d = v2_q;
    sprite_on_d = h2_q && (q != 3'd0);
    rgb_d       = sprite_on_d ? pal : 24'h000000;
  end

  // All state registers; reset clears shadows and flushes in-flight pixels.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sx_q        <= 10'd0;
      sy_q        <= 10'd0;
      sflip_q     <= 1'b0;
      addr_q      <= 10'd0;
      v1_q        <= 1'b0;
      h1_q        <= 1'b0;
      v2_q        <= 1'b0;
      h2_q        <= 1'b0;
      valid_out_q <= 1'b0;
      sprite_on_q <= 1'b0;
      rgb_q       <= 24'h000000;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      sflip_q     <= sflip_d;
      addr_q      <= addr_d;
      v1_q        <= v1_d;
      h1_q        <= h1_d;
      v2_q        <= v2_d;
      h2_q        <= h2_d;
      valid_out_q <= valid_out_d;
      sprite_on_q <= sprite_on_d;
      rgb_q       <= rgb_d;
    end
  end

  assign ADDR      = addr_q;
  assign valid_out = valid_out_q;
  assign sprite_on = sprite_on_q;
  assign rgb       = rgb_q;

endmodule
